fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch-side counterpart of the branch processing unit. Consumes its pc_src/prediction outputs, owns the PC register and next-PC selection.
//  Carries fetch-time prediction metadata through D and E. Returns pc_e, pc_src_pred_e and target_match_e to branch resolution.
//  Sits between the branch processing unit, the hazard unit and instruction memory; also keeps branch/mispredict counters.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  CNT_WIDTH   32             width of saturating performance counters
// PORTS
//  clk_i              in   1          clock; all state updates on rising edge
//  reset_n_i          in   1          asynchronous, active-low reset
//  stall_f_i          in   1          hold PC register
//  stall_d_i          in   1          hold F->D metadata register
//  stall_e_i          in   1          hold D->E metadata register
//  flush_d_i          in   1          clear F->D register (sync)
//  flush_e_i          in   1          clear D->E register (sync)
//  pc_src_i           in   2          next-PC select from branch processing unit
//  pred_pc_target_f_i in   32         predicted target for current fetch
//  pc_src_pred_f_i    in   1          prediction taken for current fetch
//  pc_target_e_i      in   32         resolved branch/jump target in E
//  branch_op_e_i      in   2          branch class in E (00 = not a branch)
//  pc_f_o             out  32         current fetch PC
//  pc_plus4_f_o       out  32         pc_f_o + 4
//  pc_e_o             out  32         PC of instruction in E
//  pc_plus4_e_o       out  32         pc_e_o + 4
//  pc_src_pred_e_o    out  1          fetch-time prediction of instruction in E
//  target_match_e_o   out  1          predicted target equals resolved target
//  branch_cnt_o       out  CNT_WIDTH  branches retired from E
//  mispredict_cnt_o   out  CNT_WIDTH  E-stage redirects
// BEHAVIOUR
//  pc_src_i encoding (package constants):
//   PC_SRC_SEQ=00 -> pc+4
//   PC_SRC_PRED=01 -> pred_pc_target_f_i
//   PC_SRC_TGT_E=10 -> pc_target_e_i
//   PC_SRC_RCV_E=11 -> pc_plus4_e_o
//  Next-PC priority:
//   - reset > E redirect (10/11, ignores stall_f_i) > stall_f_i (hold) > 00/01.
//   - An E redirect during stall_f_i still loads the new PC.
//  Reset (async, reset_n_i=0):
//   - pc_f_o=RESET_PC.
//   - All D/E metadata regs clear: valid=0, pc=0, pred=0, target=0.
//   - Both counters=0.
//   - All outputs therefore reset to 0, except pc_f_o=RESET_PC and pc_plus4_f_o=RESET_PC+4.
//  F->D register {valid,pc,pc_plus4,pred,pred_target}:
//   - Loads each cycle unless stall_d_i.
//   - flush_d_i wins over stall_d_i and clears all fields to 0.
//   - valid_d is set only when a fetch actually advances (!stall_f_i).
//  D->E register: same rules with stall_e_i/flush_e_i; flush wins.
//  PC arithmetic: PC-related arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
//  Combinational outputs:
//   - pc_src_pred_e_o = valid_e & pred_e.
//   - target_match_e_o = valid_e & (pred_target_e == pc_target_e_i). Output is 0 whenever valid_e=0.
//  Latency:
//   - pc_f_o updates 1 cycle after pc_src_i is sampled.
//   - Prediction metadata reaches E 2 cycles after fetch, absent stalls.
//  Counters (saturate at all-ones, never wrap):
//   - branch_cnt increments when valid_e & branch_op_e_i!=0 & !stall_e_i.
//   - mispredict_cnt increments when pc_src_i[1] & valid_e & !stall_e_i.
//   - Both may increment in the same cycle.
//  Simultaneous flush_e_i and redirect: redirect PC is taken; the E register clears next cycle.
//  Reset mid-operation: asserting reset_n_i mid-cycle clears state immediately; the first post-reset fetch is RESET_PC.
// STRUCTURE
//  Package bpu_pkg: pc_src_t enum (the four encodings above), RESET_PC default, fetch_meta_t struct {valid,pc,pc_plus4,pred,pred_target}.
//  Sub-module: meta_pipe_reg, a parameterised struct register with en, sync clear, async active-low reset.
//   - Instantiated twice (F->D, D->E).
//  PC register, next-PC mux, comparator and counters live in the top.
// TESTING
//  1. Reset, then 3 cycles of pc_src=00 -> pc_f_o = 0x0, 0x4, 0x8, 0xC. Counters 0.
//  2. At pc_f=0x10, pc_src=01 with pred_target=0x80 and pred=1.
//     -> next pc_f_o=0x80. Two cycles later pc_e_o=0x10 and pc_src_pred_e_o=1.
//     -> With pc_target_e_i=0x80, target_match_e_o=1.
//  3. Instruction in E pc_e=0x20 predicted taken, resolved not-taken, pc_src=11.
//     -> next pc_f_o=0x24 even with stall_f_i=1. mispredict_cnt +1.
//  4. stall_d_i=1 and flush_d_i=1 in the same cycle -> D register cleared.
//     -> That slot later reaches E with pc_src_pred_e_o=0 and target_match_e_o=0. No branch_cnt increment.
//  5. Force branch_cnt to all-ones, then retire a branch -> branch_cnt holds all-ones.
//  6. PC=0xFFFF_FFFC, pc_src=00 -> pc_f_o=0x0.
//     -> reset_n_i pulsed mid-cycle forces pc_f_o=RESET_PC asynchronously.

Source files
------------

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the fetch redirect path
package bpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_SEQ   = 2'b00,
    PC_SRC_PRED  = 2'b01,
    PC_SRC_TGT_E = 2'b10,
    PC_SRC_RCV_E = 2'b11
  } pc_src_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred;
    logic [31:0] pred_target;
  } fetch_meta_t;

endpackage

// File: rtl/meta_pipe_reg.sv
// rtl/meta_pipe_reg.sv - pipeline register for a packed struct with enable and sync clear
module meta_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clr_i,
  input  T     d_i,
  output T     q_o
);

  // Clear beats enable so a flush always wins over a stall.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC register, next-PC select, F->D->E prediction metadata and branch counters
module fetch_redirect_unit
  import bpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 stall_f_i,
  input  logic                 stall_d_i,
  input  logic                 stall_e_i,
  input  logic                 flush_d_i,
  input  logic                 flush_e_i,
  input  logic [1:0]           pc_src_i,
  input  logic [31:0]          pred_pc_target_f_i,
  input  logic                 pc_src_pred_f_i,
  input  logic [31:0]          pc_target_e_i,
  input  logic [1:0]           branch_op_e_i,
  output logic [31:0]          pc_f_o,
  output logic [31:0]          pc_plus4_f_o,
  output logic [31:0]          pc_e_o,
  output logic [31:0]          pc_plus4_e_o,
  output logic                 pc_src_pred_e_o,
  output logic                 target_match_e_o,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  pc_src_t     pc_sel;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  fetch_meta_t meta_f;
  fetch_meta_t meta_d;
  fetch_meta_t meta_e;
  logic        e_redirect;

  assign pc_sel       = pc_src_t'(pc_src_i);
  assign e_redirect   = pc_src_i[1];
  assign pc_plus4_f_o = pc_q + 32'd4;
  assign pc_f_o       = pc_q;

  // E-stage redirects override a fetch stall; sequential/predicted paths honour it.
  always_comb begin
    pc_next = pc_q;
    unique case (pc_sel)
      PC_SRC_TGT_E: pc_next = pc_target_e_i;
      PC_SRC_RCV_E: pc_next = meta_e.pc_plus4;
      PC_SRC_PRED:  pc_next = stall_f_i ? pc_q : pred_pc_target_f_i;
      PC_SRC_SEQ:   pc_next = stall_f_i ? pc_q : pc_plus4_f_o;
      default:      pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // A stalled fetch still presents a PC, but it enters D as a bubble.
  always_comb begin
    meta_f             = '0;
    meta_f.valid       = !stall_f_i;
    meta_f.pc          = pc_q;
    meta_f.pc_plus4    = pc_plus4_f_o;
    meta_f.pred        = pc_src_pred_f_i;
    meta_f.pred_target = pred_pc_target_f_i;
  end

  meta_pipe_reg #(.T(fetch_meta_t)) u_fd_reg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (!stall_d_i),
    .clr_i     (flush_d_i),
    .d_i       (meta_f),
    .q_o       (meta_d)
  );

  meta_pipe_reg #(.T(fetch_meta_t)) u_de_reg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (!stall_e_i),
    .clr_i     (flush_e_i),
    .d_i       (meta_d),
    .q_o       (meta_e)
  );

  assign pc_e_o           = meta_e.pc;
  assign pc_plus4_e_o     = meta_e.pc_plus4;
  assign pc_src_pred_e_o  = meta_e.valid & meta_e.pred;
  assign target_match_e_o = meta_e.valid & (meta_e.pred_target == pc_target_e_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (meta_e.valid && (branch_op_e_i != 2'b00) && !stall_e_i && (branch_cnt_o != CNT_MAX)) begin
        branch_cnt_o <= branch_cnt_o + 1'b1;
      end
      if (e_redirect && meta_e.valid && !stall_e_i && (mispredict_cnt_o != CNT_MAX)) begin
        mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed and randomized checks of fetch_redirect_unit
module tb_fetch_redirect_unit;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall_f = 1'b0, stall_d = 1'b0, stall_e = 1'b0;
  logic          flush_d = 1'b0, flush_e = 1'b0;
  logic [1:0]    pc_src = 2'b00;
  logic [31:0]   pred_tgt = '0;
  logic          pred_f = 1'b0;
  logic [31:0]   tgt_e = '0;
  logic [1:0]    bop = 2'b00;
  logic [31:0]   pc_f, pc_plus4_f, pc_e, pc_plus4_e;
  logic          pred_e, match_e;
  logic [CW-1:0] bcnt, mcnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .stall_f_i          (stall_f),
    .stall_d_i          (stall_d),
    .stall_e_i          (stall_e),
    .flush_d_i          (flush_d),
    .flush_e_i          (flush_e),
    .pc_src_i           (pc_src),
    .pred_pc_target_f_i (pred_tgt),
    .pc_src_pred_f_i    (pred_f),
    .pc_target_e_i      (tgt_e),
    .branch_op_e_i      (bop),
    .pc_f_o             (pc_f),
    .pc_plus4_f_o       (pc_plus4_f),
    .pc_e_o             (pc_e),
    .pc_plus4_e_o       (pc_plus4_e),
    .pc_src_pred_e_o    (pred_e),
    .target_match_e_o   (match_e),
    .branch_cnt_o       (bcnt),
    .mispredict_cnt_o   (mcnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_f = 0; stall_d = 0; stall_e = 0; flush_d = 0; flush_e = 0;
    pc_src = 2'b00; pred_tgt = '0; pred_f = 0; tgt_e = '0; bop = 2'b00;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #1;
    total++; if (pc_f !== 32'h0) $display("FAIL rst_pc_f got %h want %h", pc_f, 32'h0); else passed++;
    total++; if (pc_plus4_f !== 32'h4) $display("FAIL rst_pc_plus4_f got %h want %h", pc_plus4_f, 32'h4); else passed++;
    total++; if ({pc_e, pc_plus4_e} !== 64'h0) $display("FAIL rst_pc_e got %h/%h want 0", pc_e, pc_plus4_e); else passed++;
    total++; if ({pred_e, match_e} !== 2'b00) $display("FAIL rst_flags got %b want 00", {pred_e, match_e}); else passed++;
    total++; if ({bcnt, mcnt} !== '0) $display("FAIL rst_counters got %h/%h want 0", bcnt, mcnt); else passed++;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_sequential();
    total++; if (pc_f !== 32'h0) $display("FAIL seq_pc0 got %h want %h", pc_f, 32'h0); else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (pc_f !== 32'(4 * i)) $display("FAIL seq_pc%0d got %h want %h", i, pc_f, 32'(4 * i)); else passed++;
    end
    total++; if ({bcnt, mcnt} !== '0) $display("FAIL seq_counters got %h/%h want 0", bcnt, mcnt); else passed++;
  endtask

  task automatic test_predict();
    tick();
    total++; if (pc_f !== 32'h10) $display("FAIL pred_start got %h want %h", pc_f, 32'h10); else passed++;
    pc_src = 2'b01; pred_tgt = 32'h80; pred_f = 1;
    tick();
    total++; if (pc_f !== 32'h80) $display("FAIL pred_pc_f got %h want %h", pc_f, 32'h80); else passed++;
    pc_src = 2'b00; pred_tgt = '0; pred_f = 0;
    tick();
    tgt_e = 32'h80;
    #1;
    total++; if (pc_e !== 32'h10) $display("FAIL pred_pc_e got %h want %h", pc_e, 32'h10); else passed++;
    total++; if (pred_e !== 1'b1) $display("FAIL pred_e got %b want 1", pred_e); else passed++;
    total++; if (match_e !== 1'b1) $display("FAIL pred_match got %b want 1", match_e); else passed++;
    bop = 2'b01;
    tick();
    bop = 2'b00;
    total++; if (bcnt !== CW'(1)) $display("FAIL pred_branch_cnt got %0d want 1", bcnt); else passed++;
  endtask

  task automatic test_recover();
    apply_reset();
    pc_src = 2'b10; tgt_e = 32'h20;
    tick();
    pc_src = 2'b01; pred_f = 1; pred_tgt = 32'h40; tgt_e = '0;
    tick();
    pc_src = 2'b00; pred_f = 0; pred_tgt = '0;
    tick();
    total++; if (pc_e !== 32'h20) $display("FAIL rcv_pc_e got %h want %h", pc_e, 32'h20); else passed++;
    total++; if (pred_e !== 1'b1) $display("FAIL rcv_pred_e got %b want 1", pred_e); else passed++;
    total++; if (pc_plus4_e !== 32'h24) $display("FAIL rcv_pc_plus4_e got %h want %h", pc_plus4_e, 32'h24); else passed++;
    total++; if (mcnt !== '0) $display("FAIL rcv_mcnt_before got %0d want 0", mcnt); else passed++;
    pc_src = 2'b11; stall_f = 1;
    tick();
    clear_inputs();
    total++; if (pc_f !== 32'h24) $display("FAIL rcv_pc_f got %h want %h", pc_f, 32'h24); else passed++;
    total++; if (mcnt !== CW'(1)) $display("FAIL rcv_mcnt got %0d want 1", mcnt); else passed++;
  endtask

  task automatic test_flush_stall_d();
    apply_reset();
    tick(); tick(); tick();
    stall_d = 1; flush_d = 1; pred_f = 1; pred_tgt = 32'h99;
    tick();
    stall_d = 0; flush_d = 0; pred_f = 0; pred_tgt = '0;
    tick();
    bop = 2'b01; tgt_e = '0;
    #1;
    total++; if (pc_e !== 32'h0) $display("FAIL fl_pc_e got %h want %h", pc_e, 32'h0); else passed++;
    total++; if (pred_e !== 1'b0) $display("FAIL fl_pred_e got %b want 0", pred_e); else passed++;
    total++; if (match_e !== 1'b0) $display("FAIL fl_match got %b want 0", match_e); else passed++;
    tick();
    bop = 2'b00;
    total++; if (bcnt !== '0) $display("FAIL fl_branch_cnt got %0d want 0", bcnt); else passed++;
  endtask

  task automatic test_saturate();
    apply_reset();
    bop = 2'b10;
    for (int i = 0; i < 22; i++) tick();
    total++; if (bcnt !== CMAX) $display("FAIL sat_bcnt got %h want %h", bcnt, CMAX); else passed++;
    tick();
    bop = 2'b00;
    total++; if (bcnt !== CMAX) $display("FAIL sat_bcnt_hold got %h want %h", bcnt, CMAX); else passed++;
  endtask

  task automatic test_wrap_async_reset();
    apply_reset();
    pc_src = 2'b10; tgt_e = 32'hFFFF_FFFC;
    tick();
    pc_src = 2'b00; tgt_e = '0;
    total++; if (pc_f !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top got %h want %h", pc_f, 32'hFFFF_FFFC); else passed++;
    total++; if (pc_plus4_f !== 32'h0) $display("FAIL wrap_plus4 got %h want %h", pc_plus4_f, 32'h0); else passed++;
    tick();
    total++; if (pc_f !== 32'h0) $display("FAIL wrap_pc got %h want %h", pc_f, 32'h0); else passed++;
    tick();
    #2 reset_n = 0;
    #1;
    total++; if (pc_f !== 32'h0) $display("FAIL async_rst_pc got %h want %h", pc_f, 32'h0); else passed++;
    total++; if (pc_plus4_f !== 32'h4) $display("FAIL async_rst_plus4 got %h want %h", pc_plus4_f, 32'h4); else passed++;
    @(negedge clk);
    reset_n = 1;
    tick();
    total++; if (pc_f !== 32'h4) $display("FAIL post_rst_pc got %h want %h", pc_f, 32'h4); else passed++;
  endtask

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [31:0] pc4;
    bit        p;
    bit [31:0] t;
  } slot_t;

  task automatic test_random();
    slot_t     sd, se, nd, ne, empty;
    bit [31:0] mpc, npc;
    int        mb, mm;
    empty = '{v: 0, pc: 0, pc4: 0, p: 0, t: 0};
    apply_reset();
    sd = empty; se = empty; mpc = 32'h0; mb = 0; mm = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall_f  = ($urandom_range(0, 4) == 0);
      stall_d  = ($urandom_range(0, 4) == 0);
      stall_e  = ($urandom_range(0, 5) == 0);
      flush_d  = ($urandom_range(0, 8) == 0);
      flush_e  = ($urandom_range(0, 8) == 0);
      pc_src   = 2'($urandom_range(0, 3));
      pred_f   = 1'($urandom);
      pred_tgt = {$urandom_range(0, 255), 2'b00};
      tgt_e    = ($urandom_range(0, 1) == 1) ? se.t : {$urandom_range(0, 255), 2'b00};
      bop      = 2'($urandom_range(0, 3));
      #1;
      total++; if (pc_f !== mpc) $display("FAIL rnd%0d pc_f got %h want %h", cyc, pc_f, mpc); else passed++;
      total++; if (pc_plus4_f !== mpc + 32'd4) $display("FAIL rnd%0d pc_plus4_f got %h want %h", cyc, pc_plus4_f, mpc + 32'd4); else passed++;
      total++; if ({pc_e, pc_plus4_e} !== {se.pc, se.pc4}) $display("FAIL rnd%0d pc_e got %h/%h want %h/%h", cyc, pc_e, pc_plus4_e, se.pc, se.pc4); else passed++;
      total++; if (pred_e !== (se.v && se.p)) $display("FAIL rnd%0d pred_e got %b want %b", cyc, pred_e, se.v && se.p); else passed++;
      total++; if (match_e !== (se.v && se.t == tgt_e)) $display("FAIL rnd%0d match got %b want %b", cyc, match_e, se.v && se.t == tgt_e); else passed++;
      total++; if (bcnt !== CW'(mb) || mcnt !== CW'(mm)) $display("FAIL rnd%0d counters got %0d/%0d want %0d/%0d", cyc, bcnt, mcnt, mb, mm); else passed++;
      if (pc_src == 2'b10)      npc = tgt_e;
      else if (pc_src == 2'b11) npc = se.pc4;
      else if (stall_f)         npc = mpc;
      else if (pc_src == 2'b01) npc = pred_tgt;
      else                      npc = mpc + 32'd4;
      if (flush_d)      nd = empty;
      else if (stall_d) nd = sd;
      else              nd = '{v: !stall_f, pc: mpc, pc4: mpc + 32'd4, p: pred_f, t: pred_tgt};
      if (flush_e)      ne = empty;
      else if (stall_e) ne = se;
      else              ne = sd;
      if (se.v && bop != 0 && !stall_e && mb < int'(CMAX)) mb++;
      if (se.v && pc_src[1] && !stall_e && mm < int'(CMAX)) mm++;
      tick();
      mpc = npc; sd = nd; se = ne;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_recover();
    test_flush_stall_d();
    test_saturate();
    test_wrap_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
